run_detect_sched: RTL and testbench
===================================

# run_detect_sched

Round-robin scheduler that shares one serial run-length detector (Mealy FSM: input `x`, 2-bit output `y`, run code 01/10/11 for 1/2/≥3 ones following a 0) among up to NREQ requesters. Each requester submits a WIDTH-bit word. The block arbitrates, flushes the detector, and shifts the word in LSB-first. It accumulates the detector's per-bit output and returns a per-job summary (hit count, maximum run code) tagged with the requester ID.

## Interface
- NREQ, 4, number of requesters (2..8)
- WIDTH, 8, bits per job word (≥2)
- IDW, clog2(NREQ), requester ID width (derived)
- CW, clog2(WIDTH)+1, hit counter width (derived)

- clk  in  1  clock; all state changes on posedge
- rst  in  1  reset, synchronous, active-high
- req  in  NREQ  level request, one bit per requester
- data  in  NREQ*WIDTH  job words; requester i owns bits [i*WIDTH +: WIDTH]
- ack  out  NREQ  one-cycle grant/accept pulse; data[i] is captured on the edge that raises ack[i]
- busy  out  1  high in every state except IDLE
- det_x  out  1  serial bit to detector x
- det_rst  out  1  detector reset
- det_y  in  2  detector Mealy output, combinational from det_x and detector state
- res_valid  out  1  one-cycle result strobe
- res_id  out  IDW  requester served
- res_hits  out  CW  count of shift cycles with det_y != 00
- res_max  out  2  largest det_y seen during the job (00 if none)

## Operation
- States: IDLE, FLUSH, SHIFT, DONE. All outputs are registered except det_rst.
- **Reset:**
  - State IDLE, round-robin pointer ptr = 0.
  - ack = 0, busy = 0, res_valid = 0, res_id = 0, res_hits = 0, res_max = 00, det_x = 1.
  - det_rst = 1 combinationally while rst is high.
- **IDLE:**
  - If req == 0, remain in IDLE.
  - Otherwise grant g = the first set req bit searching ptr, ptr+1, …, wrapping modulo NREQ.
  - At that edge: ack[g] <= 1, shreg <= data[g], id <= g, hits <= 0, max <= 00, state <= FLUSH.
- **FLUSH (1 cycle):**
  - det_rst = 1 and det_x = 1. The detector resets on the mid-cycle negedge; x = 1 holds it in its start state at the closing posedge.
  - ack drops. Next state is SHIFT with bit index 0.
- **SHIFT (WIDTH cycles):**
  - det_x = shreg[idx], LSB first. det_y is sampled in the same cycle.
  - If det_y != 00: hits += 1, and max <= det_y when det_y > max (unsigned compare).
  - At idx == WIDTH-1, go to DONE.
- **DONE (1 cycle):**
  - res_valid = 1, with res_id / res_hits / res_max holding the job values.
  - ptr <= (id+1) mod NREQ, det_x = 1, next state IDLE.
  - res_* hold their values until the next DONE. Only res_valid pulses.
- **Requests:**
  - req is sampled only in IDLE. A req raised or dropped during a job has no effect until IDLE.
  - A requester that keeps req high after its ack is re-served only after all other pending requesters, per ptr order.
  - data[i] must be stable on the grant edge. It is not referenced afterwards.
- Bits of req at positions ≥ NREQ do not exist. An ID is never out of range.

## Timing
- Grant decided at edge E0 (IDLE with req != 0): ack high during cycle 1 (FLUSH), SHIFT during cycles 2..WIDTH+1, res_valid during cycle WIDTH+2, IDLE at cycle WIDTH+3.
- The earliest next grant is the edge ending cycle WIDTH+3. Back-to-back job period is WIDTH+3 cycles.
- det_rst is high during FLUSH and during reset, low otherwise.
- **rst mid-job:**
  - The job is abandoned with no res_valid, and ack clears.
  - The detector is reset via det_rst. ptr returns to 0.
- Simultaneous requests: exactly one ack bit is ever high.

## Test plan
- **Single job.** Requester 0 only, data = 8'b0011_0110, WIDTH=8.
  - ack[0] pulses in cycle 1.
  - res_valid in cycle 10 with id 0, hits 2, max 10.
- **Run codes.**
  - Data 8'b0000_1110 → hits 1, max 11.
  - Data 8'b0101_0101 → hits 3, max 01.
  - Data 8'hFF → hits 0, max 00.
- **Round-robin order.** All four req held high.
  - Grants in order 0,1,2,3,0.
  - Each res_valid is 11 cycles apart, with the matching res_id.
  - ack is one-hot every cycle.
- **Fairness / skip.** req = 4'b1010 with ptr = 0 → grant 1, then 3, then 1. Bits 0 and 2 are never acked.
- **Flush isolation.** A job ending mid-run (data 8'b1110_0000, detector left in its ≥3-ones state) is followed by data 8'b0000_0010.
  - The second job must report hits 1, max 01, so no carry-over from the first job.
- **Reset mid-SHIFT.** rst asserted in cycle 5 of a job.
  - No res_valid. The next cycle shows busy 0, det_x 1, det_rst 1.
  - A fresh request after rst is released is granted from ptr 0 and returns correct results.

Source files
------------

// File: rtl/run_detect_sched.sv
// Round-robin scheduler feeding job words LSB-first into one shared
// serial run-length detector, returning per-job hit count and max code.
//
// Ports:
//   clk, rst        clock, synchronous active-high reset
//   req, data       per-requester level request and job word
//   ack             one-cycle grant pulse (data captured on that edge)
//   busy            high whenever not IDLE
//   det_x, det_rst  serial bit and reset toward the detector
//   det_y           detector Mealy output (combinational from det_x)
//   res_valid       one-cycle result strobe
//   res_id          requester served
//   res_hits        shift cycles with det_y != 00
//   res_max         largest det_y seen during the job
module run_detect_sched #(
    parameter int NREQ  = 4,
    parameter int WIDTH = 8,
    parameter int IDW   = $clog2(NREQ),
    parameter int CW    = $clog2(WIDTH) + 1
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic [NREQ-1:0]       req,
    input  logic [NREQ*WIDTH-1:0] data,
    output logic [NREQ-1:0]       ack,
    output logic                  busy,
    output logic                  det_x,
    output logic                  det_rst,
    input  logic [1:0]            det_y,
    output logic                  res_valid,
    output logic [IDW-1:0]        res_id,
    output logic [CW-1:0]         res_hits,
    output logic [1:0]            res_max
);

    localparam int XW = $clog2(WIDTH);

    typedef enum logic [1:0] {
        IDLE,
        FLUSH,
        SHIFT,
        DONE
    } state_t;

    state_t           state;
    logic [IDW-1:0]   ptr;
    logic [IDW-1:0]   id;
    logic [WIDTH-1:0] shreg;
    logic [XW-1:0]    idx;
    logic [XW-1:0]    idx_nxt;
    logic [CW-1:0]    hits;
    logic [CW-1:0]    hits_nxt;
    logic [1:0]       mx;
    logic [1:0]       mx_nxt;
    logic [IDW-1:0]   gnt;
    logic             found;
    int               j;

    // Only det_rst is combinational: it must cover the reset cycle itself.
    assign det_rst = rst || (state == FLUSH);

    // First requester at or after ptr, wrapping modulo NREQ.
    always_comb begin
        gnt   = '0;
        found = 1'b0;
        j     = 0;
        for (int k = 0; k < NREQ; k++) begin
            j = (int'(ptr) + k) % NREQ;
            if (!found && req[j]) begin
                found = 1'b1;
                gnt   = IDW'(j);
            end
        end
    end

    assign idx_nxt  = idx + 1'b1;
    assign hits_nxt = hits + CW'(det_y != 2'b00);
    assign mx_nxt   = (det_y > mx) ? det_y : mx;

    always_ff @(posedge clk) begin
        if (rst) begin
            state     <= IDLE;
            ptr       <= '0;
            id        <= '0;
            shreg     <= '0;
            idx       <= '0;
            hits      <= '0;
            mx        <= 2'b00;
            ack       <= '0;
            busy      <= 1'b0;
            det_x     <= 1'b1;
            res_valid <= 1'b0;
            res_id    <= '0;
            res_hits  <= '0;
            res_max   <= 2'b00;
        end else begin
            unique case (state)
                IDLE: begin
                    det_x     <= 1'b1;
                    res_valid <= 1'b0;
                    ack       <= '0;
                    if (found) begin
                        ack[gnt] <= 1'b1;
                        shreg    <= data[gnt*WIDTH +: WIDTH];
                        id       <= gnt;
                        hits     <= '0;
                        mx       <= 2'b00;
                        busy     <= 1'b1;
                        state    <= FLUSH;
                    end else begin
                        busy <= 1'b0;
                    end
                end
                FLUSH: begin
                    // Detector is held in reset this cycle; first data
                    // bit is presented in the first SHIFT cycle.
                    ack   <= '0;
                    idx   <= '0;
                    det_x <= shreg[0];
                    state <= SHIFT;
                end
                SHIFT: begin
                    hits <= hits_nxt;
                    mx   <= mx_nxt;
                    if (idx == XW'(WIDTH - 1)) begin
                        // Result includes this final sample of det_y.
                        det_x     <= 1'b1;
                        res_valid <= 1'b1;
                        res_id    <= id;
                        res_hits  <= hits_nxt;
                        res_max   <= mx_nxt;
                        state     <= DONE;
                    end else begin
                        idx   <= idx_nxt;
                        det_x <= shreg[idx_nxt];
                    end
                end
                DONE: begin
                    res_valid <= 1'b0;
                    det_x     <= 1'b1;
                    busy      <= 1'b0;
                    ptr       <= (id == IDW'(NREQ - 1)) ? '0 : id + 1'b1;
                    state     <= IDLE;
                end
                default: begin
                    state <= IDLE;
                    busy  <= 1'b0;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_run_detect_sched.sv
// Randomized self-checking bench for run_detect_sched with a
// behavioural run-length detector and a job-timeline reference model.
module tb_run_detect_sched;

    localparam int NREQ  = 4;
    localparam int WIDTH = 8;
    localparam int IDW   = 2;
    localparam int CW    = 4;

    logic                  clk = 1'b0;
    logic                  rst = 1'b1;
    logic [NREQ-1:0]       req = '0;
    logic [NREQ*WIDTH-1:0] data = '0;
    logic [NREQ-1:0]       ack;
    logic                  busy;
    logic                  det_x;
    logic                  det_rst;
    logic [1:0]            det_y;
    logic                  res_valid;
    logic [IDW-1:0]        res_id;
    logic [CW-1:0]         res_hits;
    logic [1:0]            res_max;

    always #5 clk = ~clk;

    run_detect_sched #(.NREQ(NREQ), .WIDTH(WIDTH)) dut (
        .clk(clk), .rst(rst), .req(req), .data(data), .ack(ack),
        .busy(busy), .det_x(det_x), .det_rst(det_rst), .det_y(det_y),
        .res_valid(res_valid), .res_id(res_id), .res_hits(res_hits),
        .res_max(res_max)
    );

    // Detector: 0 start, 1 after a zero, 2/3/4 = one/two/>=3 ones after a zero.
    logic [2:0] dst;
    logic [2:0] dm1;
    assign dm1   = dst - 3'd1;
    assign det_y = (!det_x && dst >= 3'd2) ? dm1[1:0] : 2'b00;
    always @(posedge clk or negedge clk) begin
        if (clk)
            dst <= det_x ? ((dst == 3'd0 || dst == 3'd4) ? dst : dst + 3'd1) : 3'd1;
        else if (det_rst)
            dst <= 3'd0;
    end

    int n_cmp = 0;
    int n_bad = 0;

    // Model: p = cycle within job (0 = idle, 1 = ack, WIDTH+2 = result).
    int p = 0, mid = 0, mptr = 0, eid = 0, eh = 0, em = 0;
    logic [WIDTH-1:0] mword = '0;
    int lit_q[$];
    int glog[$];

    task automatic chk(input string nm, input int act, input int exp);
        n_cmp++;
        if (act != exp) begin
            n_bad++;
            $display("FAIL %s: got %0d expected %0d at %0t", nm, act, exp, $time);
        end
    endtask

    // Runs of ones closed by a zero, counted only after a zero was seen.
    function automatic void ref_job(input logic [WIDTH-1:0] w,
                                    output int h, output int m);
        int run;
        bit seen0;
        h = 0; m = 0; run = 0; seen0 = 0;
        for (int i = 0; i < WIDTH; i++) begin
            if (w[i]) begin
                if (seen0) run++;
            end else begin
                if (run > 0) begin
                    h++;
                    if ((run > 3 ? 3 : run) > m) m = (run > 3 ? 3 : run);
                end
                run = 0;
                seen0 = 1;
            end
        end
    endfunction

    function automatic int rr(input logic [NREQ-1:0] r, input int ptr);
        for (int k = 0; k < NREQ; k++)
            if (r[(ptr + k) % NREQ]) return (ptr + k) % NREQ;
        return -1;
    endfunction

    task automatic model_step();
        if (rst) begin
            p = 0; mptr = 0; eid = 0; eh = 0; em = 0;
        end else if (p == 0) begin
            if (req != 0) begin
                mid   = rr(req, mptr);
                mword = data[mid*WIDTH +: WIDTH];
                p     = 1;
            end
        end else if (p == WIDTH + 2) begin
            mptr = (mid + 1) % NREQ;
            p    = 0;
        end else begin
            p++;
            if (p == WIDTH + 2) begin
                eid = mid;
                ref_job(mword, eh, em);
            end
        end
    endtask

    task automatic compare();
        int ex;
        chk("ack", int'(ack), (p == 1) ? (1 << mid) : 0);
        chk("busy", int'(busy), (p != 0) ? 1 : 0);
        chk("res_valid", int'(res_valid), (p == WIDTH + 2) ? 1 : 0);
        chk("det_rst", int'(det_rst), (rst || p == 1) ? 1 : 0);
        ex = (p >= 2 && p <= WIDTH + 1) ? int'(mword[p-2]) : 1;
        chk("det_x", int'(det_x), ex);
        chk("res_id", int'(res_id), eid);
        chk("res_hits", int'(res_hits), eh);
        chk("res_max", int'(res_max), em);
        if (res_valid && lit_q.size() > 0)
            chk("lit_res", int'(res_id)*100 + int'(res_hits)*10 + int'(res_max),
                lit_q.pop_front());
        for (int i = 0; i < NREQ; i++)
            if (ack[i]) glog.push_back(i);
    endtask

    task automatic tick();
        model_step();
        @(negedge clk);
        compare();
    endtask

    task automatic job(input logic [NREQ-1:0] r, input logic [WIDTH-1:0] w,
                       input int lit);
        lit_q.push_back(lit);
        data = {NREQ{w}};
        req  = r;
        tick();
        req = '0;
        for (int i = 0; i < WIDTH + 2; i++) tick();
    endtask

    task automatic do_reset();
        rst = 1'b1;
        req = '0;
        tick();
        rst = 1'b0;
    endtask

    initial begin
        int h, m;
        int exp_rr[5] = '{0, 1, 2, 3, 0};
        int exp_fr[3] = '{1, 3, 1};

        ref_job(8'h36, h, m); chk("model_36", h*10 + m, 22);
        ref_job(8'h0E, h, m); chk("model_0E", h*10 + m, 13);
        ref_job(8'h55, h, m); chk("model_55", h*10 + m, 31);
        ref_job(8'h02, h, m); chk("model_02", h*10 + m, 11);

        rst = 1'b1;
        repeat (3) tick();
        rst = 1'b0;
        tick();

        job(4'b0001, 8'h36, 22);
        job(4'b0001, 8'h0E, 13);
        job(4'b0001, 8'h55, 31);
        job(4'b0001, 8'hFF, 0);
        job(4'b0001, 8'hE0, 0);
        job(4'b0001, 8'h02, 11);

        do_reset();
        glog.delete();
        req  = 4'hF;
        data = {$urandom};
        repeat (5 * (WIDTH + 3)) tick();
        req = '0;
        repeat (WIDTH + 4) tick();
        chk("rr_count", glog.size(), 5);
        for (int i = 0; i < 5; i++)
            if (i < glog.size()) chk("rr_order", glog[i], exp_rr[i]);

        do_reset();
        glog.delete();
        req = 4'b1010;
        repeat (3 * (WIDTH + 3)) tick();
        req = '0;
        repeat (WIDTH + 4) tick();
        chk("fair_count", glog.size(), 3);
        for (int i = 0; i < 3; i++)
            if (i < glog.size()) chk("fair_order", glog[i], exp_fr[i]);

        do_reset();
        data = {NREQ{8'hA5}};
        req  = 4'b0001;
        tick();
        req = '0;
        repeat (4) tick();
        rst = 1'b1;
        tick();
        chk("rst_busy", int'(busy), 0);
        chk("rst_detx", int'(det_x), 1);
        chk("rst_detrst", int'(det_rst), 1);
        chk("rst_valid", int'(res_valid), 0);
        tick();
        rst = 1'b0;
        job(4'b1001, 8'h36, 22);

        for (int c = 0; c < 3000; c++) begin
            if ($urandom_range(0, 7) == 0) req = NREQ'($urandom);
            data = NREQ*WIDTH'($urandom);
            rst  = ($urandom_range(0, 299) == 0);
            tick();
        end
        rst = 1'b0;
        req = '0;
        repeat (WIDTH + 4) tick();
        chk("lit_drained", lit_q.size(), 0);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
